// File: rtl/branch_resolve_unit.sv
// Queues fetch predictions and checks them in order against execute outcomes; training/redirect outputs 1 cycle after a resolve.
// Push backpressure via pred_ready_o (deasserted while full); BR_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_unit #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clock_i,
  input  logic        rst_n_i,
  input  logic        pred_valid_i,
  input  logic [31:0] pred_pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_tgt_i,
  output logic        pred_ready_o,
  input  logic        res_valid_i,
  input  logic [31:0] res_pc_i,
  input  logic        res_taken_i,
  input  logic [31:0] res_tgt_i,
  output logic [31:0] update_pc_o,
  output logic [31:0] update_tgt_o,
  output logic        last_br_o,
  output logic        update_pht_o,
  output logic        update_btb_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic [31:0] stat_resolved_o,
  output logic [31:0] stat_mispred_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } pred_t;

  localparam logic [PTR_W:0] PTR_ONE = 1;

  pred_t          mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           mispredict;
  pred_t          head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign pred_ready_o = !full;

  assign push = pred_valid_i && !full;
  assign pop  = res_valid_i && !empty;

  // An empty queue resolves against an all-zero record: a not-taken guess at pc 0.
  assign head = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  assign mispredict = res_valid_i &&
                      ((head.taken != res_taken_i) ||
                       (res_taken_i && (head.tgt != res_tgt_i)) ||
                       (head.pc != res_pc_i));

  always_ff @(posedge clock_i) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= '{pc: pred_pc_i, taken: pred_taken_i, tgt: pred_tgt_i};
    end
  end

  // A mispredict empties the queue and discards any push in the same cycle.
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (mispredict) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      update_pc_o   <= '0;
      update_tgt_o  <= '0;
      last_br_o     <= 1'b0;
      update_pht_o  <= 1'b0;
      update_btb_o  <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      flush_o       <= 1'b0;
    end else begin
      update_pht_o <= res_valid_i;
      update_btb_o <= res_valid_i && res_taken_i;
      redirect_o   <= mispredict;
      flush_o      <= mispredict;
      if (res_valid_i) begin
        update_pc_o  <= res_pc_i;
        update_tgt_o <= res_tgt_i;
        last_br_o    <= res_taken_i;
      end
      if (mispredict) begin
        redirect_pc_o <= res_taken_i ? res_tgt_i : (res_pc_i + 32'd4);
      end
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_resolved_o <= '0;
      stat_mispred_o  <= '0;
    end else begin
      if (res_valid_i && (stat_resolved_o != 32'hFFFF_FFFF)) stat_resolved_o <= stat_resolved_o + 32'd1;
      if (mispredict && (stat_mispred_o != 32'hFFFF_FFFF))   stat_mispred_o  <= stat_mispred_o + 32'd1;
    end
  end
`else
  assign stat_resolved_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven vectors plus a queue model/scoreboard for branch_resolve_unit.
module tb_branch_resolve_unit;

  localparam int DEPTH = 8;

  logic        clock_i = 1'b0;
  logic        rst_n_i;
  logic        pred_valid_i;
  logic [31:0] pred_pc_i;
  logic        pred_taken_i;
  logic [31:0] pred_tgt_i;
  logic        pred_ready_o;
  logic        res_valid_i;
  logic [31:0] res_pc_i;
  logic        res_taken_i;
  logic [31:0] res_tgt_i;
  logic [31:0] update_pc_o;
  logic [31:0] update_tgt_o;
  logic        last_br_o;
  logic        update_pht_o;
  logic        update_btb_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic [31:0] stat_resolved_o;
  logic [31:0] stat_mispred_o;

  branch_resolve_unit #(.DEPTH(DEPTH)) dut (
    .clock_i(clock_i), .rst_n_i(rst_n_i),
    .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i), .pred_taken_i(pred_taken_i),
    .pred_tgt_i(pred_tgt_i), .pred_ready_o(pred_ready_o),
    .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_taken_i(res_taken_i), .res_tgt_i(res_tgt_i),
    .update_pc_o(update_pc_o), .update_tgt_o(update_tgt_o), .last_br_o(last_br_o),
    .update_pht_o(update_pht_o), .update_btb_o(update_btb_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .stat_resolved_o(stat_resolved_o), .stat_mispred_o(stat_mispred_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic        pv;
    logic [31:0] ppc;
    logic        pt;
    logic [31:0] ptgt;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtgt;
    logic        exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_res = 0;
  int   n_mis = 0;
  bit   mon_on = 1'b0;
  ent_t mq[$];
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptgt,
                              input logic rv, input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
                              input logic exp_redir, input logic [31:0] exp_rpc);
    vec_t v;
    v = '{pv: pv, ppc: ppc, pt: pt, ptgt: ptgt, rv: rv, rpc: rpc, rt: rt, rtgt: rtgt,
          exp_redir: exp_redir, exp_rpc: exp_rpc};
    return v;
  endfunction

  // One cycle of stimulus; the model predicts what the DUT shows one cycle later.
  task automatic step(input vec_t v);
    ent_t head;
    logic mis;
    logic rdy;
    exp_t e;
    @(negedge clock_i);
    rdy = (mq.size() < DEPTH);
    chk("pred_ready", {31'd0, pred_ready_o}, {31'd0, rdy});
    pred_valid_i = v.pv; pred_pc_i = v.ppc; pred_taken_i = v.pt; pred_tgt_i = v.ptgt;
    res_valid_i  = v.rv; res_pc_i  = v.rpc; res_taken_i  = v.rt; res_tgt_i  = v.rtgt;
    if (v.rv) begin
      head = (mq.size() != 0) ? mq[0] : '0;
      mis  = (head.taken != v.rt) || (v.rt && (head.tgt != v.rtgt)) || (head.pc != v.rpc);
      e    = '{pc: v.rpc, tgt: v.rtgt, taken: v.rt, redir: mis,
               rpc: v.rt ? v.rtgt : v.rpc + 32'd4};
      exp_q.push_back(e);
      n_res++;
      if (mis) n_mis++;
      if (mis) mq.delete();
      else begin
        if (mq.size() != 0) void'(mq.pop_front());
        if (v.pv && rdy) mq.push_back('{pc: v.ppc, taken: v.pt, tgt: v.ptgt});
      end
    end else if (v.pv && rdy) begin
      mq.push_back('{pc: v.ppc, taken: v.pt, tgt: v.ptgt});
    end
  endtask

  always @(negedge clock_i) begin
    if (mon_on) begin
      if (update_pht_o) begin
        if (exp_q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("update_pc", update_pc_o, mon_e.pc);
          chk("update_tgt", update_tgt_o, mon_e.tgt);
          chk("last_br", {31'd0, last_br_o}, {31'd0, mon_e.taken});
          chk("update_btb", {31'd0, update_btb_o}, {31'd0, mon_e.taken});
          chk("redirect", {31'd0, redirect_o}, {31'd0, mon_e.redir});
          if (mon_e.redir) chk("redirect_pc", redirect_pc_o, mon_e.rpc);
        end
      end else begin
        chk("strobes_idle", {29'd0, update_btb_o, redirect_o, flush_o}, 32'd0);
      end
      chk("flush_eq_redirect", {31'd0, flush_o}, {31'd0, redirect_o});
    end
  end

  initial begin
    vec_t idle;
    idle = '0;
    rst_n_i = 1'b0;
    pred_valid_i = 0; pred_pc_i = 0; pred_taken_i = 0; pred_tgt_i = 0;
    res_valid_i = 0; res_pc_i = 0; res_taken_i = 0; res_tgt_i = 0;

    //            pv  ppc           pt  ptgt     rv  rpc           rt  rtgt     redir rpc
    tbl.push_back(mk(1, 32'h100,      1, 32'h200, 0, 0,             0, 0,       0, 0));
    tbl.push_back(mk(0, 0,            0, 0,       1, 32'h100,       1, 32'h200, 0, 0));
    tbl.push_back(mk(1, 32'h104,      0, 0,       0, 0,             0, 0,       0, 0));
    tbl.push_back(mk(1, 32'h500,      1, 32'h600, 1, 32'h104,       1, 32'h40,  1, 32'h40));
    tbl.push_back(mk(0, 0,            0, 0,       1, 32'h500,       1, 32'h600, 1, 32'h600));
    tbl.push_back(mk(0, 0,            0, 0,       1, 32'h200,       1, 32'h80,  1, 32'h80));
    tbl.push_back(mk(1, 32'h108,      1, 32'h300, 0, 0,             0, 0,       0, 0));
    tbl.push_back(mk(0, 0,            0, 0,       1, 32'h108,       0, 0,       1, 32'h10C));
    tbl.push_back(mk(1, 32'h10,       0, 0,       0, 0,             0, 0,       0, 0));
    tbl.push_back(mk(1, 32'h20,       1, 32'h30,  0, 0,             0, 0,       0, 0));
    tbl.push_back(mk(1, 32'h40,       0, 0,       1, 32'h10,        0, 0,       0, 0));
    tbl.push_back(mk(0, 0,            0, 0,       1, 32'h20,        1, 32'h30,  0, 0));
    tbl.push_back(mk(0, 0,            0, 0,       1, 32'h40,        0, 0,       0, 0));
    tbl.push_back(mk(1, 32'hFFFFFFFC, 1, 32'h8,   0, 0,             0, 0,       0, 0));
    tbl.push_back(mk(0, 0,            0, 0,       1, 32'hFFFFFFFC,  0, 0,       1, 32'h0));
    tbl.push_back(mk(1, 32'h60,       0, 0,       0, 0,             0, 0,       0, 0));
    tbl.push_back(mk(0, 0,            0, 0,       1, 32'h64,        0, 0,       1, 32'h68));
    tbl.push_back(mk(1, 32'h70,       1, 32'h80,  0, 0,             0, 0,       0, 0));
    tbl.push_back(mk(0, 0,            0, 0,       1, 32'h70,        1, 32'h84,  1, 32'h84));
    tbl.push_back(mk(1, 32'h90,       0, 32'h123, 0, 0,             0, 0,       0, 0));
    tbl.push_back(mk(0, 0,            0, 0,       1, 32'h90,        0, 32'h456, 0, 0));

    #12;
    @(negedge clock_i);
    rst_n_i = 1'b1;
    #1;
    chk("rst_update_pc", update_pc_o, 32'd0);
    chk("rst_update_tgt", update_tgt_o, 32'd0);
    chk("rst_redirect_pc", redirect_pc_o, 32'd0);
    chk("rst_strobes", {27'd0, last_br_o, update_pht_o, update_btb_o, redirect_o, flush_o}, 32'd0);
    chk("rst_ready", {31'd0, pred_ready_o}, 32'd1);
    chk("rst_stat_resolved", stat_resolved_o, 32'd0);
    chk("rst_stat_mispred", stat_mispred_o, 32'd0);
    mon_on = 1'b1;

    for (int i = 0; i < 10; i++) step(idle);

    foreach (tbl[i]) begin
      step(tbl[i]);
      @(posedge clock_i);
      #1;
      if (tbl[i].rv) begin
        chk("tbl_redirect", {31'd0, redirect_o}, {31'd0, tbl[i].exp_redir});
        if (tbl[i].exp_redir) chk("tbl_redirect_pc", redirect_pc_o, tbl[i].exp_rpc);
      end
    end

    // Fill to capacity; the ninth push must be refused.
    for (int i = 0; i < 9; i++)
      step(mk(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 1, 32'h1000, 0, 0, 0, 0));
    step(idle);

    // Stream pushes and in-order resolves so both pointers wrap.
    for (int i = 0; i < 27; i++) begin
      vec_t v;
      v = idle;
      if (i < 20) begin
        v.pv = 1; v.ppc = 32'h3000 + 32'(4 * i); v.pt = i[0]; v.ptgt = 32'h4000 + 32'(i);
      end
      if (mq.size() != 0) begin
        v.rv = 1; v.rpc = mq[0].pc; v.rt = mq[0].taken; v.rtgt = mq[0].tgt;
      end
      step(v);
    end
    step(idle);
    step(idle);

`ifdef BR_STATS_EN
    chk("stat_resolved", stat_resolved_o, 32'(n_res));
    chk("stat_mispred", stat_mispred_o, 32'(n_mis));
`else
    chk("stat_resolved_tied", stat_resolved_o, 32'd0);
    chk("stat_mispred_tied", stat_mispred_o, 32'd0);
`endif

    // Reset between a resolve and its strobe.
    step(mk(1, 32'h700, 1, 32'h800, 0, 0, 0, 0, 0, 0));
    step(mk(1, 32'h200, 1, 32'h80, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 1, 32'h700, 1, 32'h800, 0, 0));
    @(posedge clock_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("midrst_strobes", {29'd0, update_pht_o, update_btb_o, redirect_o}, 32'd0);
    chk("midrst_ready", {31'd0, pred_ready_o}, 32'd1);
    chk("midrst_update_pc", update_pc_o, 32'd0);
    exp_q.delete();
    mq.delete();
    n_res = 0;
    n_mis = 0;
    @(negedge clock_i);
    res_valid_i = 0;
    pred_valid_i = 0;
    rst_n_i = 1'b1;
    // A surviving queue would match this resolve and hide the redirect.
    step(mk(0, 0, 0, 0, 1, 32'h200, 1, 32'h80, 0, 0));
    @(posedge clock_i);
    #1;
    chk("post_rst_redirect", {31'd0, redirect_o}, 32'd1);
    chk("post_rst_redirect_pc", redirect_pc_o, 32'h80);
    step(idle);
    step(idle);

`ifdef BR_STATS_EN
    chk("stat_resolved_after_rst", stat_resolved_o, 32'(n_res));
    chk("stat_mispred_after_rst", stat_mispred_o, 32'(n_mis));
`endif
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
